// File: rtl/shift_reg_univ.sv
// Universal shift register: hold / shift right / shift left / parallel load, with word counter.
// Optional even-parity output enabled by defining SHREG_PARITY_EN.
module shift_reg_univ #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic             sdo,
    output logic             word_done
`ifdef SHREG_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        M_HOLD = 2'b00,
        M_SHR  = 2'b01,
        M_SHL  = 2'b10,
        M_LOAD = 2'b11
    } mode_e;

    mode_e            op;
    logic [WIDTH-1:0] q, q_nxt;
    logic             dir_q, dir_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             wd_nxt;
    logic             last;

    assign op   = mode_e'(mode);
    assign last = (cnt == CNT_LAST);

    always_comb begin
        q_nxt   = q;
        dir_nxt = dir_q;
        cnt_nxt = cnt;
        wd_nxt  = 1'b0;
        if (en) begin
            unique case (op)
                M_HOLD: ;
                M_SHR: begin
                    q_nxt   = {sin, q[WIDTH-1:1]};
                    dir_nxt = 1'b0;
                    cnt_nxt = last ? '0 : cnt + CW'(1);
                    wd_nxt  = last;
                end
                M_SHL: begin
                    q_nxt   = {q[WIDTH-2:0], sin};
                    dir_nxt = 1'b1;
                    cnt_nxt = last ? '0 : cnt + CW'(1);
                    wd_nxt  = last;
                end
                M_LOAD: begin
                    q_nxt   = pin;
                    cnt_nxt = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q         <= RESET_VAL;
            dir_q     <= 1'b0;
            cnt       <= '0;
            word_done <= 1'b0;
        end else begin
            q         <= q_nxt;
            dir_q     <= dir_nxt;
            cnt       <= cnt_nxt;
            word_done <= wd_nxt;
        end
    end

    // sdo follows the last shift direction, so changing mode alone never glitches it
    assign pout = q;
    assign sdo  = dir_q ? q[WIDTH-1] : q[0];

`ifdef SHREG_PARITY_EN
    assign parity = ^q;
`endif

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register that generalises the fixed 4-stage serial-in/serial-out chain. It supports hold, shift-right, shift-left and parallel load, giving SISO, SIPO, PISO and PIPO operation from one block. A shift counter flags each completed word, and a synchronous reset gives a known state. It sits between serial links and word-wide datapaths in the same designs that use the plain SISO chain.

## Interface
- `WIDTH`, default 4: number of register stages; legal range 2..64.
- `RESET_VAL`, default 0: value loaded into the register on reset; WIDTH bits.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  clock enable; when low, all state is held.
- `mode`  in  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `sin`  in  1  serial data input.
- `pin`  in  WIDTH  parallel load data.
- `pout`  out  WIDTH  register contents.
- `sdo`  out  1  serial data output.
- `word_done`  out  1  one-cycle pulse marking WIDTH completed shifts.
- `parity`  out  1  even parity of `pout`; present only with `SHREG_PARITY_EN`.

## Operation
- **Register `q[WIDTH-1:0]`:** `pout = q`.
- **Shift right (01):**
  - `q <= {sin, q[WIDTH-1:1]}`; `sin` enters the MSB.
  - `sdo` takes the value from the LSB.
- **Shift left (10):**
  - `q <= {q[WIDTH-2:0], sin}`; `sin` enters the LSB.
  - `sdo` takes the value from the MSB.
- **Parallel load (11):** `q <= pin`.
- **Hold (00):** `q` unchanged.
- **Direction flag `dir_q`:**
  - Registered; set to 0 on a right shift and to 1 on a left shift.
  - Unchanged by load and hold.
  - `sdo = dir_q ? q[WIDTH-1] : q[0]`, so `sdo` does not change combinationally with `mode`.
- **Shift counter `cnt`:**
  - Width `$clog2(WIDTH)`.
  - Increments on every shift while `en` is high, in either direction.
  - On the shift where `cnt == WIDTH-1`: `cnt` wraps to 0 and `word_done` is registered high for the following cycle.
  - A direction change mid-word does not reset `cnt`.
- **Parallel load:** clears `cnt` and suppresses `word_done`.
- **`en` low:**
  - `q`, `dir_q` and `cnt` are held.
  - `word_done` is driven 0 on the next edge.
- **Undefined states:** none; every `mode` value is decoded.

## Timing
- **Reset values, all outputs:**
  - `q = RESET_VAL`, so `pout = RESET_VAL`.
  - `dir_q = 0`, so `sdo = RESET_VAL[0]`.
  - `cnt = 0`.
  - `word_done = 0`.
  - `parity = ^RESET_VAL`.
- **Reset priority:** `rst` has priority over `en` and `mode`.
- **Reset mid-word:** discards the partial count; no `word_done` pulse is produced.
- **Serial latency:** with continuous shift right, a bit presented on `sin` before edge k appears on `sdo` after edge k+WIDTH-1, i.e. after WIDTH edges in total. This matches the 4-FF chain when WIDTH=4.
- **Parallel load latency:** `pout` reflects `pin` one edge after `mode=11` is sampled.
- **`word_done`:**
  - High for exactly one cycle, in the cycle after the WIDTH-th shift edge.
  - Back-to-back words produce pulses spaced exactly WIDTH cycles apart.
- **Simultaneous events:** load on the same edge as the WIDTH-th shift cannot occur, because `mode` is single-valued. Load always wins over counting.
- **`parity`:** combinational from `q`; valid in the same cycle as `pout`.

## Configuration
- **Macro:** `SHREG_PARITY_EN`.
- **Defined:** `parity` port exists and equals the XOR reduction of `q`. It updates with every register change, including at reset.
- **Undefined:** `parity` port and its logic are absent; all other behaviour is identical.

## Test plan
- **Reset:** WIDTH=4, RESET_VAL=4'b1010, assert `rst` for 2 cycles -> `pout=1010`, `sdo=0`, `word_done=0`, `parity=0`.
- **SISO latency:** WIDTH=4, shift right, `sin` sequence 1,0,1,1 -> `sdo` shows 1,0,1,1 starting after the 4th edge. `word_done` pulses once, one cycle after the 4th shift.
- **SIPO:** WIDTH=8, shift left, `sin` 1,1,0,0,1,0,1,0 (first bit first) -> `pout=8'hCA` after 8 edges, and `word_done` pulses.
- **PISO:**
  - WIDTH=8, load `pin=8'hA5`, then 8 right shifts with `sin=0` -> `sdo` shows 1,0,1,0,0,1,0,1.
  - The load clears `cnt`, and `word_done` pulses only after the 8th shift.
- **Enable and reset mid-word:**
  - WIDTH=4: 2 shifts, `en=0` for 3 cycles -> `pout` is frozen and `word_done=0`.
  - 2 more shifts -> `word_done` pulses.
  - Repeat with `rst` after 2 shifts -> no pulse, and `cnt` restarts from 0.
- **Parity build:**
  - With `SHREG_PARITY_EN`: load `8'h07` -> `parity=1`; load `8'h03` -> `parity=0`.
  - Without the macro, the design elaborates with no `parity` port.
